// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x DATA_W general-purpose register file with $0 tied to zero,
// two combinational read ports with write-first bypass, one write-back port,
// and a per-register pending-write scoreboard that raises the decode stall.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [4:0]        issue_dst,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [32];
    logic [CNT_W-1:0]  cnt  [32];
    logic              err_q;

    logic              wb_live;
    logic              hz_rs;
    logic              hz_rt;
    logic              full;
    logic              accepted;
    logic [31:0]       inc_vec;
    logic [31:0]       dec_vec;

    // A write-back to $0 is a no-op everywhere: storage, bypass, scoreboard, error.
    assign wb_live = wb_en && (wb_addr != 5'd0);

    // Read ports: $0 reads zero, a same-cycle write-back wins over storage.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != 5'd0) begin
            if (wb_en && (wb_addr == rs_addr)) rs_data = wb_data;
            else                               rs_data = regs[rs_addr];
        end
        if (rt_addr != 5'd0) begin
            if (wb_en && (wb_addr == rt_addr)) rt_data = wb_data;
            else                               rt_data = regs[rt_addr];
        end
    end

    // Hazard detection: a source is clear if nothing is pending, or the only
    // pending write is retiring this cycle (its value arrives via the bypass).
    // The destination counter is full unless a write-back frees a slot now.
    always_comb begin
        hz_rs = rs_used && (rs_addr != 5'd0) && (cnt[rs_addr] != '0) &&
                !((cnt[rs_addr] == CNT_ONE) && wb_en && (wb_addr == rs_addr));
        hz_rt = rt_used && (rt_addr != 5'd0) && (cnt[rt_addr] != '0) &&
                !((cnt[rt_addr] == CNT_ONE) && wb_en && (wb_addr == rt_addr));
        full  = issue_wr && (issue_dst != 5'd0) && (cnt[issue_dst] == CNT_MAX) &&
                !(wb_en && (wb_addr == issue_dst));
        stall    = issue_valid && (hz_rs || hz_rt || full);
        accepted = issue_valid && !stall;
    end

    // One-hot increment/decrement requests; bit 0 is never set so cnt[0] stays 0.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (accepted && issue_wr && (issue_dst != 5'd0)) inc_vec[issue_dst] = 1'b1;
        if (wb_live && (cnt[wb_addr] != '0))            dec_vec[wb_addr]   = 1'b1;
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Pending-write counters: simultaneous issue and retire cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                case ({inc_vec[r], dec_vec[r]})
                    2'b10:   cnt[r] <= cnt[r] + CNT_ONE;
                    2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
                    default: cnt[r] <= cnt[r];
                endcase
            end
        end
    end

    // Sticky flag for a write-back nobody was waiting on.
    always_ff @(posedge clk) begin
        if (rst)                                err_q <= 1'b0;
        else if (wb_live && (cnt[wb_addr] == '0)) err_q <= 1'b1;
    end

    assign err_underflow = err_q;

endmodule
